// File: rtl/rgb565_grayscale_multi_ise.sv
// rgb565_grayscale_multi_ise
// Custom-instruction unit: four RGB565 pixels (two in valueA, two in valueB)
// are converted into four packed 8-bit grayscale bytes. PIXELS_PER_STEP
// converters run in parallel, so an instruction takes 4/PIXELS_PER_STEP busy
// cycles. SWAP_BYTES handles big-endian camera data. The result is zero
// except during the single done cycle, so it can be ORed onto a shared bus.

// Protocol checker: assertions about the unit's observable behaviour.
module rgb565_grayscale_multi_ise_chk #(
    parameter logic [1:0] CNT_LAST = 2'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        done,
    input  logic [31:0] result,
    input  logic [1:0]  state,
    input  logic [1:0]  cnt
);

    // Result must read as zero whenever no completion is signalled.
    a_result_gated: assert property (@(posedge clk) disable iff (rst)
        !done |-> (result == 32'd0));

    // A completion pulse is exactly one cycle wide.
    a_done_single: assert property (@(posedge clk) disable iff (rst)
        done |=> !done);

    // The unused state encoding is never reached.
    a_state_legal: assert property (@(posedge clk) disable iff (rst)
        state != 2'd3);

    // The step counter never runs past the final step.
    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        cnt <= CNT_LAST);

endmodule

module rgb565_grayscale_multi_ise #(
    parameter logic [7:0] customInstructionId = 8'd0,
    parameter int         PIXELS_PER_STEP     = 1,
    parameter bit         SWAP_BYTES          = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  iseId,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    localparam int         STEPS    = 4 / PIXELS_PER_STEP;
    localparam logic [1:0] CNT_LAST = 2'(STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One RGB565 pixel to an 8-bit luma value. Channels are widened to 8 bits
    // by replicating their MSBs; the weighted sum peaks at 255*256, so 16 bits
    // hold it exactly and the top byte is the truncated result.
    function automatic logic [7:0] rgb565_to_gray(input logic [15:0] pix);
        logic [15:0] p;
        logic [7:0]  r8;
        logic [7:0]  g8;
        logic [7:0]  b8;
        logic [15:0] sum;
        if (SWAP_BYTES) begin
            p = {pix[7:0], pix[15:8]};
        end else begin
            p = pix;
        end
        r8  = {p[15:11], p[15:13]};
        g8  = {p[10:5],  p[10:9]};
        b8  = {p[4:0],   p[4:2]};
        sum = (16'd54  * {8'd0, r8})
            + (16'd183 * {8'd0, g8})
            + (16'd19  * {8'd0, b8});
        return 8'(sum >> 8);
    endfunction

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [63:0] operand_q;
    logic [63:0] operand_d;
    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic        done_q;
    logic        done_d;
    logic [31:0] result_q;
    logic [31:0] result_d;

    logic        accept_s;
    logic [1:0]  pix_idx_s [PIXELS_PER_STEP];
    logic [7:0]  gray_s    [PIXELS_PER_STEP];

    // Only our own ID is honoured, and only when no operation is in flight.
    assign accept_s = start
                   && (iseId == customInstructionId)
                   && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Converter bank: lane g handles pixel cnt*P+g of the captured operands.
    for (genvar g = 0; g < PIXELS_PER_STEP; g++) begin : g_conv
        assign pix_idx_s[g] = (cnt_q * 2'(PIXELS_PER_STEP)) + 2'(g);
        assign gray_s[g]    = rgb565_to_gray(operand_q[{pix_idx_s[g], 4'b0000} +: 16]);
    end

    // Next-state, datapath update and registered-output preparation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        done_d    = 1'b0;
        result_d  = 32'd0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    operand_d = {valueB, valueA};
                    cnt_d     = 2'd0;
                    acc_d     = 32'd0;
                    state_d   = ST_BUSY;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_BUSY: begin
                for (int k = 0; k < PIXELS_PER_STEP; k++) begin
                    acc_d[{pix_idx_s[k], 3'b000} +: 8] = gray_s[k];
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = 2'd0;
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    result_d = acc_d;
                end else begin
                    cnt_d    = cnt_q + 2'd1;
                    state_d  = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // State and datapath registers; reset returns everything to idle zeros.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            operand_q <= 64'd0;
            acc_q     <= 32'd0;
            done_q    <= 1'b0;
            result_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

    rgb565_grayscale_multi_ise_chk #(
        .CNT_LAST (CNT_LAST)
    ) u_chk (
        .clk    (clock),
        .rst    (reset),
        .done   (done_q),
        .result (result_q),
        .state  (state_q),
        .cnt    (cnt_q)
    );

endmodule

// File: tb/tb_rgb565_grayscale_multi_ise.sv
// Bench for rgb565_grayscale_multi_ise: four instances (P=1, P=2, P=4 with
// ID 0, and a byte-swapping P=1 instance with ID 0x5A) share one stimulus.
// Cycle 0 is the cycle in which start is presented.
module tb_rgb565_grayscale_multi_ise;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  iseId;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic        done_w [4];
    logic [31:0] res_w  [4];

    int          n_vec;
    int          n_err;
    int          cyc;
    int          dcnt [4];
    int          dcyc [4][4];
    logic [31:0] dres [4][4];
    int          leak [4];
    int          lat  [3];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  id;
        logic [31:0] exp_main;
        logic [31:0] exp_swap;
    } vec_t;

    vec_t vecs [6];

    rgb565_grayscale_multi_ise #(.customInstructionId(8'h00), .PIXELS_PER_STEP(1), .SWAP_BYTES(1'b0)) u_p1 (
        .clock(clock), .reset(reset), .start(start), .iseId(iseId),
        .valueA(valueA), .valueB(valueB), .done(done_w[0]), .result(res_w[0]));
    rgb565_grayscale_multi_ise #(.customInstructionId(8'h00), .PIXELS_PER_STEP(2), .SWAP_BYTES(1'b0)) u_p2 (
        .clock(clock), .reset(reset), .start(start), .iseId(iseId),
        .valueA(valueA), .valueB(valueB), .done(done_w[1]), .result(res_w[1]));
    rgb565_grayscale_multi_ise #(.customInstructionId(8'h00), .PIXELS_PER_STEP(4), .SWAP_BYTES(1'b0)) u_p4 (
        .clock(clock), .reset(reset), .start(start), .iseId(iseId),
        .valueA(valueA), .valueB(valueB), .done(done_w[2]), .result(res_w[2]));
    rgb565_grayscale_multi_ise #(.customInstructionId(8'h5A), .PIXELS_PER_STEP(1), .SWAP_BYTES(1'b1)) u_sw (
        .clock(clock), .reset(reset), .start(start), .iseId(iseId),
        .valueA(valueA), .valueB(valueB), .done(done_w[3]), .result(res_w[3]));

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic begin_op();
        cyc = 0;
        for (int d = 0; d < 4; d++) begin
            dcnt[d] = 0;
            leak[d] = 0;
        end
    endtask

    task automatic sample();
        for (int d = 0; d < 4; d++) begin
            if (done_w[d] === 1'b1) begin
                if (dcnt[d] < 4) begin
                    dcyc[d][dcnt[d]] = cyc;
                    dres[d][dcnt[d]] = res_w[d];
                end
                dcnt[d]++;
            end else if (res_w[d] !== 32'd0) begin
                leak[d]++;
            end
        end
    endtask

    // One clock cycle: drive inputs, sample outputs mid-cycle, advance.
    task automatic tick(input logic rst, input logic s, input logic [7:0] id,
                        input logic [31:0] a, input logic [31:0] b);
        reset  = rst;
        start  = s;
        iseId  = id;
        valueA = a;
        valueB = b;
        @(negedge clock);
        sample();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic check_dut(input int d, input string nm, input int exp_n,
                             input int c0, input logic [31:0] r0,
                             input int c1, input logic [31:0] r1);
        cmp({nm, "_done_count"}, 32'(dcnt[d]), 32'(exp_n));
        if (exp_n >= 1 && dcnt[d] >= 1) begin
            cmp({nm, "_done_cycle0"}, 32'(dcyc[d][0]), 32'(c0));
            cmp({nm, "_result0"}, dres[d][0], r0);
        end
        if (exp_n >= 2 && dcnt[d] >= 2) begin
            cmp({nm, "_done_cycle1"}, 32'(dcyc[d][1]), 32'(c1));
            cmp({nm, "_result1"}, dres[d][1], r1);
        end
        cmp({nm, "_zero_when_idle"}, 32'(leak[d]), 32'd0);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        lat[0] = 5;
        lat[1] = 3;
        lat[2] = 2;

        vecs[0] = '{a: 32'hF800FFFF, b: 32'h001F07E0, id: 8'h00, exp_main: 32'h12B635FF, exp_swap: 32'h0};
        vecs[1] = '{a: 32'h00F8E007, b: 32'h00000000, id: 8'h5A, exp_main: 32'h0,        exp_swap: 32'h000035B6};
        vecs[2] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, id: 8'h00, exp_main: 32'hFFFFFFFF, exp_swap: 32'h0};
        vecs[3] = '{a: 32'h84108410, b: 32'h84108410, id: 8'h00, exp_main: 32'h82828282, exp_swap: 32'h0};
        vecs[4] = '{a: 32'h00200001, b: 32'h12340800, id: 8'h00, exp_main: 32'h40010200, exp_swap: 32'h0};
        vecs[5] = '{a: 32'h10841084, b: 32'h10841084, id: 8'h5A, exp_main: 32'h0,        exp_swap: 32'h82828282};

        // Reset state.
        reset  = 1'b1;
        start  = 1'b0;
        iseId  = 8'h00;
        valueA = 32'd0;
        valueB = 32'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int d = 0; d < 4; d++) begin
            cmp($sformatf("reset_done_dut%0d", d), 32'(done_w[d]), 32'd0);
            cmp($sformatf("reset_result_dut%0d", d), res_w[d], 32'd0);
        end
        @(posedge clock);
        #1;

        // Table-driven single operations; operands are inverted after issue.
        for (int i = 0; i < 6; i++) begin
            begin_op();
            tick(1'b0, 1'b1, vecs[i].id, vecs[i].a, vecs[i].b);
            repeat (11) tick(1'b0, 1'b0, vecs[i].id, ~vecs[i].a, ~vecs[i].b);
            for (int d = 0; d < 3; d++) begin
                check_dut(d, $sformatf("vec%0d_dut%0d", i, d),
                          (vecs[i].id == 8'h00) ? 1 : 0, lat[d], vecs[i].exp_main, 0, 32'd0);
            end
            check_dut(3, $sformatf("vec%0d_dut3", i),
                      (vecs[i].id == 8'h5A) ? 1 : 0, 5, vecs[i].exp_swap, 0, 32'd0);
        end

        // Wrong ID: nobody answers.
        begin_op();
        tick(1'b0, 1'b1, 8'h33, 32'hF800FFFF, 32'h001F07E0);
        repeat (10) tick(1'b0, 1'b0, 8'h33, 32'h0, 32'h0);
        for (int d = 0; d < 4; d++) begin
            check_dut(d, $sformatf("wrong_id_dut%0d", d), 0, 0, 32'd0, 0, 32'd0);
        end

        // Start re-asserted while busy is ignored.
        begin_op();
        tick(1'b0, 1'b1, 8'h00, 32'hF800FFFF, 32'h001F07E0);
        tick(1'b0, 1'b1, 8'h00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) tick(1'b0, 1'b0, 8'h00, 32'h12345678, 32'h9ABCDEF0);
        for (int d = 0; d < 3; d++) begin
            check_dut(d, $sformatf("busy_start_dut%0d", d), 1, lat[d], 32'h12B635FF, 0, 32'd0);
        end

        // Back-to-back: second accept in the DONE cycle of the first.
        for (int d = 0; d < 3; d++) begin
            begin_op();
            tick(1'b0, 1'b1, 8'h00, 32'hF800FFFF, 32'h001F07E0);
            for (int c = 1; c < 12; c++) begin
                if (c == lat[d]) begin
                    tick(1'b0, 1'b1, 8'h00, 32'h0, 32'h0);
                end else begin
                    tick(1'b0, 1'b0, 8'h00, 32'hFFFFFFFF, 32'hFFFFFFFF);
                end
            end
            check_dut(d, $sformatf("b2b_dut%0d", d), 2, lat[d], 32'h12B635FF, 2 * lat[d], 32'h0);
            repeat (4) tick(1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
        end

        // Reset in cycle 2 aborts the operation (P=1 and P=2 still busy).
        begin_op();
        tick(1'b0, 1'b1, 8'h00, 32'hF800FFFF, 32'h001F07E0);
        tick(1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
        tick(1'b1, 1'b0, 8'h00, 32'h0, 32'h0);
        repeat (8) tick(1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
        for (int d = 0; d < 2; d++) begin
            check_dut(d, $sformatf("mid_reset_dut%0d", d), 0, 0, 32'd0, 0, 32'd0);
        end

        // Fresh operation after the reset.
        begin_op();
        tick(1'b0, 1'b1, 8'h00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (11) tick(1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
        for (int d = 0; d < 3; d++) begin
            check_dut(d, $sformatf("post_reset_dut%0d", d), 1, lat[d], 32'hFFFFFFFF, 0, 32'd0);
        end

        // Reset wins over a simultaneous accept.
        begin_op();
        tick(1'b1, 1'b1, 8'h00, 32'hF800FFFF, 32'h001F07E0);
        repeat (10) tick(1'b0, 1'b0, 8'h00, 32'h0, 32'h0);
        for (int d = 0; d < 3; d++) begin
            check_dut(d, $sformatf("reset_vs_start_dut%0d", d), 0, 0, 32'd0, 0, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
